// File: rtl/clic_irq_arbiter.sv
// CLIC interrupt arbiter: picks the highest-level eligible source (ties to higher ID),
// registers it as a candidate, and hands it to the core over a valid/ready/kill interface.
module clic_irq_arbiter #(
   parameter  int NumSrc = 256,
   parameter  int LevelW = 8,
   localparam int SrcW   = $clog2(NumSrc)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NumSrc-1:0]          ip_i,
   input  logic [NumSrc-1:0]          ie_i,
   input  logic [NumSrc*LevelW-1:0]   level_i,
   input  logic [NumSrc*2-1:0]        priv_i,
   input  logic [NumSrc-1:0]          shv_i,
   input  logic [LevelW-1:0]          thresh_i,
   output logic                       irq_valid_o,
   input  logic                       irq_ready_i,
   output logic [SrcW-1:0]            irq_id_o,
   output logic [LevelW-1:0]          irq_level_o,
   output logic [1:0]                 irq_priv_o,
   output logic                       irq_shv_o,
   output logic                       kill_req_o,
   input  logic                       kill_ack_i,
   output logic                       claim_o,
   output logic [SrcW-1:0]            claim_id_o
);

   typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

   state_t              state;
   logic                best_vld;
   logic [SrcW-1:0]     best_id;
   logic [LevelW-1:0]   best_level;
   logic                cand_vld_p1;
   logic [SrcW-1:0]     cand_id_p1;
   logic [LevelW-1:0]   cand_level_p1;
   logic [1:0]          cand_priv_p1;
   logic                cand_shv_p1;
   logic                held_ok;
   logic                preempt;

   // Ascending scan with >= lets a later (higher) ID win a level tie.
   always_comb begin
      best_vld   = 1'b0;
      best_id    = '0;
      best_level = '0;
      for (int k = 0; k < NumSrc; k++) begin
         if (ip_i[k] && ie_i[k] && (level_i[k*LevelW +: LevelW] > thresh_i) &&
             (!best_vld || (level_i[k*LevelW +: LevelW] >= best_level))) begin
            best_vld   = 1'b1;
            best_id    = SrcW'(k);
            best_level = level_i[k*LevelW +: LevelW];
         end
      end
   end

   // Stage 1 boundary: candidate register, updated every cycle regardless of FSM state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cand_vld_p1 <= 1'b0;
      else       cand_vld_p1 <= best_vld;
   end

   always_ff @(posedge clk_i) begin
      cand_id_p1    <= best_id;
      cand_level_p1 <= best_level;
      cand_priv_p1  <= priv_i[best_id*2 +: 2];
      cand_shv_p1   <= shv_i[best_id];
   end

   assign held_ok = ip_i[irq_id_o] && ie_i[irq_id_o] &&
                    (level_i[irq_id_o*LevelW +: LevelW] > thresh_i);
   assign preempt = (cand_vld_p1 && (cand_level_p1 > irq_level_o)) || !held_ok;

   // Stage 2 boundary: handshake FSM, all outputs registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         irq_valid_o <= 1'b0;
         kill_req_o  <= 1'b0;
         claim_o     <= 1'b0;
         irq_id_o    <= '0;
         irq_level_o <= '0;
         irq_priv_o  <= '0;
         irq_shv_o   <= 1'b0;
         claim_id_o  <= '0;
      end else begin
         claim_o <= 1'b0;
         case (state)
            IDLE: begin
               if (cand_vld_p1) begin
                  irq_valid_o <= 1'b1;
                  irq_id_o    <= cand_id_p1;
                  irq_level_o <= cand_level_p1;
                  irq_priv_o  <= cand_priv_p1;
                  irq_shv_o   <= cand_shv_p1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (irq_ready_i) begin
                  irq_valid_o <= 1'b0;
                  claim_o     <= 1'b1;
                  claim_id_o  <= irq_id_o;
                  state       <= IDLE;
               end else if (preempt) begin
                  irq_valid_o <= 1'b0;
                  kill_req_o  <= 1'b1;
                  state       <= KILL;
               end
            end
            KILL: begin
               if (kill_ack_i) begin
                  kill_req_o <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed bench for clic_irq_arbiter: a vector table of two-source scenarios followed
// by hand-written preemption, withdrawal, simultaneous-event and reset sequences.
module tb_clic_irq_arbiter;

   localparam int NumSrc = 256;
   localparam int LevelW = 8;
   localparam int SrcW   = 8;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NumSrc-1:0]         ip, ie, shv;
   logic [NumSrc*LevelW-1:0]  level;
   logic [NumSrc*2-1:0]       priv;
   logic [LevelW-1:0]         thresh;
   logic                      irq_valid, irq_ready, irq_shv, kill_req, kill_ack, claim;
   logic [SrcW-1:0]           irq_id, claim_id;
   logic [LevelW-1:0]         irq_level;
   logic [1:0]                irq_priv;

   int checks = 0;
   int errors = 0;

   clic_irq_arbiter #(.NumSrc(NumSrc), .LevelW(LevelW)) dut (
      .clk_i(clk), .rst_i(rst), .ip_i(ip), .ie_i(ie), .level_i(level), .priv_i(priv),
      .shv_i(shv), .thresh_i(thresh), .irq_valid_o(irq_valid), .irq_ready_i(irq_ready),
      .irq_id_o(irq_id), .irq_level_o(irq_level), .irq_priv_o(irq_priv), .irq_shv_o(irq_shv),
      .kill_req_o(kill_req), .kill_ack_i(kill_ack), .claim_o(claim), .claim_id_o(claim_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          a_id;  int a_lvl; bit a_ie;
      bit          b_vld; int b_id;  int b_lvl; bit b_ie;
      int          thr;
      bit          exp_vld; int exp_id; int exp_lvl; int exp_priv; bit exp_shv;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_src(input int id, input int lvl, input bit en);
      ip[id] = 1'b1;
      ie[id] = en;
      level[id*LevelW +: LevelW] = LevelW'(lvl);
   endtask

   task automatic clear_srcs();
      ip = '0; ie = '0; level = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; irq_ready = 1'b0; kill_ack = 1'b0;
      clear_srcs();
      tick();
      rst = 1'b0;
   endtask

   task automatic reach_req(input int id, input int lvl);
      do_reset();
      thresh = '0;
      set_src(id, lvl, 1'b1);
      tick(); tick();
      chk("reach_req_valid", irq_valid, 1);
      chk("reach_req_id", irq_id, id);
   endtask

   initial begin
      rst = 1'b1; irq_ready = 1'b0; kill_ack = 1'b0; thresh = '0;
      clear_srcs();
      // Source k carries priv = k mod 4 and shv = k mod 2.
      for (int k = 0; k < NumSrc; k++) begin
         priv[k*2 +: 2] = 2'(k % 4);
         shv[k]         = 1'(k % 2);
      end

      //        a_id lvl  ie   b?  b_id lvl  ie  thr   vld id   lvl   priv shv
      vecs[0] = '{5,   'h40, 1, 0, 0,   0,   0, 'h00, 1, 5,   'h40, 1, 1};
      vecs[1] = '{3,   'h80, 1, 1, 200, 'h80, 1, 'h80, 0, 0,   0,    0, 0};
      vecs[2] = '{3,   'h80, 1, 1, 200, 'h80, 1, 'h7F, 1, 200, 'h80, 0, 0};
      vecs[3] = '{7,   'hFF, 0, 1, 3,   'h80, 1, 'h7F, 1, 3,   'h80, 3, 1};
      vecs[4] = '{255, 'h01, 1, 1, 0,   'h02, 1, 'h00, 1, 0,   'h02, 0, 0};
      vecs[5] = '{0,   'h10, 1, 1, 1,   'h10, 1, 'h0F, 1, 1,   'h10, 1, 1};
      vecs[6] = '{100, 'h50, 1, 0, 0,   0,   0, 'h50, 0, 0,   0,    0, 0};
      vecs[7] = '{9,   'hFF, 1, 0, 0,   0,   0, 'hFE, 1, 9,   'hFF, 1, 1};

      tick();
      chk("rst_valid", irq_valid, 0);
      chk("rst_kill", kill_req, 0);
      chk("rst_claim", claim, 0);
      chk("rst_id", irq_id, 0);
      chk("rst_level", irq_level, 0);
      chk("rst_claim_id", claim_id, 0);

      for (int v = 0; v < 8; v++) begin
         do_reset();
         thresh = LevelW'(vecs[v].thr);
         set_src(vecs[v].a_id, vecs[v].a_lvl, vecs[v].a_ie);
         if (vecs[v].b_vld) set_src(vecs[v].b_id, vecs[v].b_lvl, vecs[v].b_ie);
         tick();
         chk($sformatf("v%0d_lat1_valid", v), irq_valid, 0);
         tick();
         chk($sformatf("v%0d_valid", v), irq_valid, vecs[v].exp_vld);
         if (vecs[v].exp_vld) begin
            chk($sformatf("v%0d_id", v), irq_id, vecs[v].exp_id);
            chk($sformatf("v%0d_level", v), irq_level, vecs[v].exp_lvl);
            chk($sformatf("v%0d_priv", v), irq_priv, vecs[v].exp_priv);
            chk($sformatf("v%0d_shv", v), irq_shv, vecs[v].exp_shv);
            irq_ready = 1'b1;
            ip[vecs[v].exp_id] = 1'b0;
            tick();
            irq_ready = 1'b0;
            chk($sformatf("v%0d_claim", v), claim, 1);
            chk($sformatf("v%0d_claim_id", v), claim_id, vecs[v].exp_id);
            chk($sformatf("v%0d_valid_after_claim", v), irq_valid, 0);
            tick();
            chk($sformatf("v%0d_claim_drop", v), claim, 0);
         end
      end

      // Preemption by a higher-level source.
      reach_req(10, 'h20);
      set_src(11, 'h90, 1'b1);
      for (int i = 0; i < 4 && !kill_req; i++) tick();
      chk("pre_kill", kill_req, 1);
      chk("pre_valid_low", irq_valid, 0);
      kill_ack = 1'b1;
      tick();
      chk("pre_kill_drop", kill_req, 0);
      chk("pre_no_claim0", claim, 0);
      tick();
      chk("pre_new_valid", irq_valid, 1);
      chk("pre_new_id", irq_id, 11);
      chk("pre_no_claim1", claim, 0);
      tick();
      kill_ack = 1'b0;
      chk("pre_no_claim2", claim, 0);
      chk("pre_hold_id", irq_id, 11);

      // Held source loses its enable.
      reach_req(20, 'h30);
      ie[20] = 1'b0;
      tick();
      chk("wd_kill", kill_req, 1);
      chk("wd_valid_low", irq_valid, 0);
      kill_ack = 1'b1;
      tick();
      kill_ack = 1'b0;
      chk("wd_kill_drop", kill_req, 0);
      tick(); tick();
      chk("wd_no_valid", irq_valid, 0);

      // Ready coincides with a higher candidate: claim wins, new ID one cycle later.
      reach_req(30, 'h20);
      set_src(31, 'h90, 1'b1);
      tick();
      chk("sim_still_req", irq_valid, 1);
      chk("sim_no_kill_yet", kill_req, 0);
      irq_ready = 1'b1;
      ip[30] = 1'b0;
      tick();
      irq_ready = 1'b0;
      chk("sim_claim", claim, 1);
      chk("sim_claim_id", claim_id, 30);
      chk("sim_no_kill", kill_req, 0);
      chk("sim_valid_low", irq_valid, 0);
      tick();
      chk("sim_new_valid", irq_valid, 1);
      chk("sim_new_id", irq_id, 31);
      chk("sim_claim_drop", claim, 0);

      // Asynchronous reset while in KILL.
      reach_req(40, 'h60);
      ie[40] = 1'b0;
      tick();
      chk("rk_kill", kill_req, 1);
      ie[40] = 1'b1;
      rst = 1'b1;
      #1;
      chk("rk_valid", irq_valid, 0);
      chk("rk_kill0", kill_req, 0);
      chk("rk_claim", claim, 0);
      chk("rk_id", irq_id, 0);
      chk("rk_level", irq_level, 0);
      @(negedge clk);
      rst = 1'b0;
      tick(); tick();
      chk("rk_rereq_valid", irq_valid, 1);
      chk("rk_rereq_id", irq_id, 40);
      chk("rk_rereq_level", irq_level, 'h60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule

// File: doc/clic_irq_arbiter.md
# clic_irq_arbiter

Interrupt-selection and core-handshake stage of the CLIC for the CVA6 Sclic configuration (256 sources). It compares all pending, enabled sources, picks the winner by level with ties going to the higher ID, and filters it against the current level threshold. It presents the winner to the core over the valid/ready/kill CLIC request interface and is the transmitter for the core's CLIC receiver. It sits between the CLIC register file (per-source ip/ie/level/priv/shv) and the CVA6 interrupt inputs.

## Interface
- NumSrc, 256, number of interrupt sources; legal range is 2..1024.
- LevelW, 8, width of the interrupt level field.
- SrcW, $clog2(NumSrc), ID width; derived, do not override.
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ip_i  in  NumSrc  per-source pending bit.
- ie_i  in  NumSrc  per-source enable bit.
- level_i  in  NumSrc*LevelW  per-source level; source k occupies bits [k*LevelW +: LevelW].
- priv_i  in  NumSrc*2  per-source privilege mode.
- shv_i  in  NumSrc  per-source selective-hardware-vectoring bit.
- thresh_i  in  LevelW  effective level threshold (max of mintthresh and the current mil).
- irq_valid_o  out  1  request to the core.
- irq_ready_i  in  1  core accepts the request.
- irq_id_o  out  SrcW  ID of the request.
- irq_level_o  out  LevelW  level of the request.
- irq_priv_o  out  2  privilege mode of the request.
- irq_shv_o  out  1  shv bit of the request.
- kill_req_o  out  1  withdraw the outstanding request.
- kill_ack_i  in  1  core confirms the withdrawal.
- claim_o  out  1  one-cycle pulse when a request is accepted.
- claim_id_o  out  SrcW  ID of the accepted source; valid while claim_o is high.

## Operation
- **Eligibility.** A source is eligible when ip & ie are both 1 and its level > thresh_i (strictly greater). A level equal to the threshold is not eligible.
- **Stage 1 (candidate register).** A comparator tree selects the eligible source with the maximum level. On equal levels the higher ID wins. The stage registers cand_vld, cand_id, cand_level, cand_priv and cand_shv every cycle, in every FSM state.
- **FSM states:** IDLE, REQ, KILL.
- **IDLE.**
  - If cand_vld: latch the cand_* fields into the output registers, assert irq_valid_o and go to REQ.
- **REQ.**
  - irq_valid_o is high and irq_id/level/priv/shv are stable.
  - If irq_ready_i: deassert valid, pulse claim_o with claim_id_o = irq_id_o, go to IDLE.
  - Otherwise, if a preempt condition holds, deassert valid, assert kill_req_o and go to KILL. Preempt conditions:
    - cand_vld and cand_level > irq_level_o; or
    - the held source is no longer eligible (its ip, ie, or level > thresh_i has dropped).
  - If irq_ready_i and a preempt condition occur in the same cycle, ready wins: the request is claimed and no kill is issued.
- **KILL.**
  - kill_req_o stays high until kill_ack_i is seen.
  - On kill_ack_i: drop kill_req_o and go to IDLE. No claim is issued.
  - irq_ready_i is ignored in this state.
- **Claim.** claim_o is purely informative. The register file clears ip for edge-triggered sources; clearing ip is not this block's job.
- **Output rules.** All outputs come from registers; there are no combinational paths from inputs to outputs. Output fields hold their last value while valid is low.

## Timing
- **Reset values:** state = IDLE; irq_valid_o = 0, kill_req_o = 0, claim_o = 0; irq_id_o, irq_level_o, irq_priv_o, irq_shv_o, claim_id_o all = 0; cand_vld = 0.
- **Request latency.** If ip is asserted before edge N, cand_vld is set at edge N and irq_valid_o is high after edge N+1. Total latency is 2 cycles.
- **Accept.** If ready is sampled high at edge M, valid is low and claim_o is high after edge M. claim_o is low again after edge M+1.
- **Back-to-back requests.** After a claim, the earliest next irq_valid_o is 1 cycle later (IDLE→REQ). The candidate register must already reflect the cleared ip; otherwise the same ID is re-requested.
- **Preemption.** If the preempt condition is sampled at edge P, kill_req_o is high after edge P. After kill_ack_i, the next request follows IDLE→REQ, i.e. at least 1 cycle after the kill is dropped.
- **Asynchronous reset mid-operation.** Reset forces valid and kill low immediately. No claim is generated.

## Test plan
- **Single source.** ip[5]=ie[5]=1, level[5]=0x40, thresh=0. Required: valid after 2 cycles with id=5, level=0x40. Ready high for 1 cycle gives claim_o=1 with claim_id=5.
- **Tie-break and threshold.** Sources 3 and 200 at level 0x80; source 7 at level 0xFF with ie=0; thresh=0x80. Required: no valid. Then set thresh=0x7F. Required: id=200.
- **Preemption.** While REQ holds id=10 at level 0x20, raise source 11 at level 0x90. Required: kill_req_o goes high. Hold kill_ack for 3 cycles. Required: IDLE, then a new valid with id=11. No claim is issued for id=10.
- **Source withdrawal.** In REQ, clear ie of the held source. Required: kill_req_o goes high. A kill_ack_i with no other eligible source leaves valid low.
- **Simultaneous events.** Ready coincides with the arrival of a higher candidate. Required: claim of the old ID, no kill, and the new ID is requested 1 cycle later.
- **Reset.** Assert rst_i while in KILL. Required: all outputs are 0 at once. After release, a pending source is re-requested within 2 cycles.
